// File: rtl/aap_fetch_unit.sv
// rtl/aap_fetch_unit.sv - AAP instruction fetch: halfword reads, 16/32-bit assembly, skid, redirect
module aap_fetch_unit #(
  parameter int                     PC_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_rd_en,
  output logic [PC_WIDTH-1:0] imem_rd_addr,
  input  logic [15:0]         imem_rd_data,
  output logic                fetch_valid,
  input  logic                decode_ready,
  output logic [31:0]         fetch_instr,
  output logic                fetch_is32,
  output logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target
);

  typedef enum logic {ST_LO, ST_HI} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic                pend_q;
  logic [15:0]         skid_q;
  logic                skid_v_q;
  logic [15:0]         lo_buf_q;
  logic [PC_WIDTH-1:0] lo_pc_q;
  logic [PC_WIDTH-1:0] hw_pc_q;
  logic                fetch_valid_q;
  logic [31:0]         fetch_instr_q;
  logic                fetch_is32_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;

  logic        can_load;
  logic        hw_v;
  logic [15:0] hw;
  logic        is_lo;
  logic        lo_of_32;
  logic        accept;
  logic        load_out;

  // FSM state register; reset or any redirect lands in LO
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_LO;
    else        state_q <= state_d;
  end

  // FSM next state: a 32-bit low half moves to HI, a consumed high half returns to LO
  always_comb begin
    state_d = state_q;
    if (branch_valid) begin
      state_d = ST_LO;
    end else if (accept) begin
      if (state_q == ST_LO && hw[15]) state_d = ST_HI;
      else if (state_q == ST_HI)      state_d = ST_LO;
    end
  end

  // FSM outputs: halfword selection, acceptance, output load and memory request
  always_comb begin
    can_load = !fetch_valid_q || decode_ready;
    hw_v     = skid_v_q || pend_q;
    hw       = skid_v_q ? skid_q : imem_rd_data;
    is_lo    = (state_q == ST_LO);
    lo_of_32 = is_lo && hw[15];
    // A 32-bit low half only needs lo_buf, so it never waits on the decoder
    accept   = hw_v && (lo_of_32 || can_load);
    load_out = hw_v && can_load && !lo_of_32;
    if (!reset) begin
      imem_rd_en   = 1'b0;
      imem_rd_addr = RESET_PC;
    end else if (branch_valid) begin
      imem_rd_en   = 1'b1;
      imem_rd_addr = branch_target;
    end else begin
      // With a skid entry held, the next response would have nowhere to go
      imem_rd_en   = can_load && !skid_v_q;
      imem_rd_addr = pc_q;
    end
  end

  // Datapath: request PC, pending response, skid entry, low-half buffer and output register
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      skid_q        <= 16'h0;
      skid_v_q      <= 1'b0;
      lo_buf_q      <= 16'h0;
      lo_pc_q       <= '0;
      hw_pc_q       <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'h0;
      fetch_is32_q  <= 1'b0;
      fetch_pc_q    <= '0;
    end else if (branch_valid) begin
      pc_q          <= branch_target + PC_WIDTH'(1);
      pend_q        <= 1'b1;
      skid_v_q      <= 1'b0;
      hw_pc_q       <= branch_target;
      fetch_valid_q <= 1'b0;
    end else begin
      pend_q <= imem_rd_en;
      if (imem_rd_en) pc_q <= pc_q + PC_WIDTH'(1);
      if (accept) hw_pc_q <= hw_pc_q + PC_WIDTH'(1);
      if (accept && lo_of_32) begin
        lo_buf_q <= hw;
        lo_pc_q  <= hw_pc_q;
      end
      if (load_out) begin
        fetch_valid_q <= 1'b1;
        if (is_lo) begin
          fetch_instr_q <= {16'h0, hw};
          fetch_is32_q  <= 1'b0;
          fetch_pc_q    <= hw_pc_q;
        end else begin
          fetch_instr_q <= {hw, lo_buf_q};
          fetch_is32_q  <= 1'b1;
          fetch_pc_q    <= lo_pc_q;
        end
      end else if (decode_ready) begin
        fetch_valid_q <= 1'b0;
      end
      if (skid_v_q) begin
        if (accept) skid_v_q <= 1'b0;
      end else if (pend_q && !accept) begin
        skid_q   <= imem_rd_data;
        skid_v_q <= 1'b1;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_is32  = fetch_is32_q;
  assign fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_aap_fetch_unit.sv
// tb/tb_aap_fetch_unit.sv - directed vector bench for aap_fetch_unit
module tb_aap_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_rd_en;
  logic [23:0] imem_rd_addr;
  logic [15:0] imem_rd_data;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] fetch_instr;
  logic        fetch_is32;
  logic [23:0] fetch_pc;
  logic        branch_valid;
  logic [23:0] branch_target;

  logic        reset2;
  logic        imem_rd_en2;
  logic [3:0]  imem_rd_addr2;
  logic [15:0] imem_rd_data2;
  logic        fetch_valid2;
  logic        decode_ready2;
  logic [31:0] fetch_instr2;
  logic        fetch_is322;
  logic [3:0]  fetch_pc2;
  logic        branch_valid2;
  logic [3:0]  branch_target2;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem  [0:511];
  logic [15:0] mem2 [0:15];

  aap_fetch_unit #(.PC_WIDTH(24), .RESET_PC(24'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_rd_en(imem_rd_en), .imem_rd_addr(imem_rd_addr), .imem_rd_data(imem_rd_data),
    .fetch_valid(fetch_valid), .decode_ready(decode_ready),
    .fetch_instr(fetch_instr), .fetch_is32(fetch_is32), .fetch_pc(fetch_pc),
    .branch_valid(branch_valid), .branch_target(branch_target)
  );

  aap_fetch_unit #(.PC_WIDTH(4), .RESET_PC(4'hE)) dut_w (
    .clock(clock), .reset(reset2),
    .imem_rd_en(imem_rd_en2), .imem_rd_addr(imem_rd_addr2), .imem_rd_data(imem_rd_data2),
    .fetch_valid(fetch_valid2), .decode_ready(decode_ready2),
    .fetch_instr(fetch_instr2), .fetch_is32(fetch_is322), .fetch_pc(fetch_pc2),
    .branch_valid(branch_valid2), .branch_target(branch_target2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // synchronous instruction memories: data the cycle after the request
  always @(posedge clock) begin
    if (imem_rd_en)  imem_rd_data  <= mem[imem_rd_addr[8:0]];
    if (imem_rd_en2) imem_rd_data2 <= mem2[imem_rd_addr2];
  end

  typedef struct packed {
    logic        rst;
    logic        dr;
    logic        bv;
    logic [23:0] bt;
    logic        en;
    logic [23:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        is32;
    logic [23:0] pc;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic dr, logic bv, logic [23:0] bt,
                              logic en, logic [23:0] addr, logic valid,
                              logic [31:0] instr, logic is32, logic [23:0] pc,
                              logic chk_data);
    vec_t v;
    v.rst = rst; v.dr = dr; v.bv = bv; v.bt = bt;
    v.en = en; v.addr = addr; v.valid = valid;
    v.instr = instr; v.is32 = is32; v.pc = pc; v.chk_data = chk_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    imem_rd_data = 16'h0;
    imem_rd_data2 = 16'h0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h8005; mem[5] = 16'h1234;
    mem[6] = 16'h6666; mem[7] = 16'h7777; mem[8] = 16'h1888; mem[9] = 16'h1999;
    mem[10] = 16'h8001; mem[11] = 16'h2BBB;
    mem[9'h100] = 16'h0AAA; mem[9'h101] = 16'h0BBB; mem[9'h102] = 16'h0CCC;
    mem2[14] = 16'h0777; mem2[15] = 16'h8000; mem2[0] = 16'hABCD; mem2[1] = 16'h0123;

    //                 rst dr bv bt       en addr     v  instr          32 pc       chk
    vecs.push_back(mk(0, 1, 0, 24'h0,   0, 24'h0,   0, 32'h0,        0, 24'h0,   1)); // reset state
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h0,   0, 32'h0,        0, 24'h0,   1)); // c0
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h1,   0, 32'h0,        0, 24'h0,   1));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h2,   1, 32'h1111,     0, 24'h0,   0)); // c2 first valid
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h3,   1, 32'h2222,     0, 24'h1,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h4,   1, 32'h3333,     0, 24'h2,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h5,   1, 32'h4444,     0, 24'h3,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h6,   0, 32'h0,        0, 24'h0,   0)); // lo half
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h7,   1, 32'h12348005, 1, 24'h4,   0));
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0)); // stall x5
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0));
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0));
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0));
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   0, 24'h8,   1, 32'h6666,     0, 24'h6,   0)); // skid drains
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h8,   1, 32'h7777,     0, 24'h7,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h9,   0, 32'h0,        0, 24'h0,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'hA,   1, 32'h1888,     0, 24'h8,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'hB,   1, 32'h1999,     0, 24'h9,   0));
    vecs.push_back(mk(1, 1, 1, 24'h100, 1, 24'h100, 0, 32'h0,        0, 24'h0,   0)); // branch in HI
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h101, 0, 32'h0,        0, 24'h0,   0));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h102, 1, 32'h0AAA,     0, 24'h100, 0));
    vecs.push_back(mk(1, 0, 0, 24'h0,   0, 24'h103, 1, 32'h0BBB,     0, 24'h101, 0)); // fill skid
    vecs.push_back(mk(0, 0, 0, 24'h0,   0, 24'h0,   1, 32'h0BBB,     0, 24'h101, 0)); // reset, skid_v=1
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h0,   0, 32'h0,        0, 24'h0,   1));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h1,   0, 32'h0,        0, 24'h0,   1));
    vecs.push_back(mk(1, 1, 0, 24'h0,   1, 24'h2,   1, 32'h1111,     0, 24'h0,   0));

    reset = 1'b0; decode_ready = 1'b1; branch_valid = 1'b0; branch_target = 24'h0;
    reset2 = 1'b0; decode_ready2 = 1'b1; branch_valid2 = 1'b0; branch_target2 = 4'h0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst;
      decode_ready = vecs[i].dr;
      branch_valid = vecs[i].bv;
      branch_target = vecs[i].bt;
      #1;
      check($sformatf("row%0d rd_en", i), 32'(imem_rd_en), 32'(vecs[i].en));
      check($sformatf("row%0d rd_addr", i), 32'(imem_rd_addr), 32'(vecs[i].addr));
      check($sformatf("row%0d valid", i), 32'(fetch_valid), 32'(vecs[i].valid));
      if (vecs[i].valid || vecs[i].chk_data) begin
        check($sformatf("row%0d instr", i), fetch_instr, vecs[i].instr);
        check($sformatf("row%0d is32", i), 32'(fetch_is32), 32'(vecs[i].is32));
        check($sformatf("row%0d pc", i), 32'(fetch_pc), 32'(vecs[i].pc));
      end
    end

    // address wrap: 32-bit instruction straddling 0xF -> 0x0 on a 4-bit PC
    @(negedge clock);
    reset2 = 1'b1;
    #1;
    check("wrap first req", 32'(imem_rd_addr2), 32'hE);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("wrap 16b valid", 32'(fetch_valid2), 32'h1);
    check("wrap 16b instr", fetch_instr2, 32'h0777);
    check("wrap 16b pc", 32'(fetch_pc2), 32'hE);
    check("wrap req addr", 32'(imem_rd_addr2), 32'h0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        @(negedge clock);
        #1;
        if (fetch_valid2 && fetch_is322) seen = 1'b1;
      end
      check("wrap 32b seen", 32'(seen), 32'h1);
      if (seen) begin
        check("wrap 32b instr", fetch_instr2, 32'hABCD8000);
        check("wrap 32b pc", 32'(fetch_pc2), 32'hF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
